imm_gen_pipe: RTL and testbench

//  Parametrised RV32I/RV64I immediate generator for the decode stage, with a registered output.

---
 rtl/imm_gen_pipe_pkg.sv | 23 ++
 rtl/imm_gen_pipe_decode.sv | 64 ++++++
 rtl/imm_gen_pipe.sv | 109 ++++++++++
 tb/tb_imm_gen_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: shared types for the immediate generator pipeline.
//   imm_src_t   - immediate format select, encoded as presented on immSrc
//   buf_state_t - occupancy of the two-entry output skid buffer
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_IZ  = 3'd0,  // zero-extended instr[31:20]
        IMM_I   = 3'd1,  // sign-extended instr[31:20]
        IMM_S   = 3'd2,
        IMM_B   = 3'd3,
        IMM_U   = 3'd4,
        IMM_J   = 3'd5,
        IMM_Z   = 3'd6,  // CSR uimm, zero-extended instr[19:15]
        IMM_RSV = 3'd7
    } imm_src_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,  // main register valid
        BUF_TWO   = 2'd2   // main and skid registers valid
    } buf_state_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: purely combinational immediate extraction and extension.
// Ports:
//   instr - raw 32-bit instruction word
//   src   - immediate format select
//   imm   - immediate extended to XLEN bits
//   bad   - src was the reserved encoding (imm forced to 0)
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_src_t        src,
    output logic [XLEN-1:0] imm,
    output logic            bad
);

    logic [31:0] val;
    logic        sx;

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        val = '0;
        sx  = 1'b0;
        bad = 1'b0;
        case (src)
            IMM_IZ: val = {20'b0, instr[31:20]};
            IMM_I: begin
                val = {{20{instr[31]}}, instr[31:20]};
                sx  = 1'b1;
            end
            IMM_S: begin
                val = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                sx  = 1'b1;
            end
            IMM_B: begin
                val = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                sx  = 1'b1;
            end
            IMM_U: begin
                // On RV64 the U immediate is still sign-extended from bit 31.
                val = {instr[31:12], 12'b0};
                sx  = 1'b1;
            end
            IMM_J: begin
                val = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                sx  = 1'b1;
            end
            IMM_Z: val = {27'b0, instr[19:15]};
            default: bad = 1'b1;
        endcase

        // 32-bit value is already correctly extended; widen to XLEN.
        if (sx) begin
            imm = XLEN'($signed(val));
        end else begin
            imm = XLEN'(val);
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate generator with a registered,
// two-entry skid-buffered output.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   flush               - discard all buffered entries
//   in_valid, in_ready  - input handshake (in_ready is registered)
//   instr, immSrc       - instruction word and immediate format select
//   in_tag              - sideband tag carried with the immediate
//   out_valid, out_ready- output handshake
//   immOp, out_tag      - extended immediate and its tag
//   bad_src             - entry was built from the reserved format select
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its payload while valid && !ready; out_valid
// does not depend on out_ready, and in_ready does not depend on in_valid.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int ILW   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ILW-1:0]   instr,
    input  logic [2:0]       immSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immOp,
    output logic [TAG_W-1:0] out_tag,
    output logic             bad_src
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             bad;
    } entry_t;

    buf_state_t state;
    entry_t     m_q;   // main entry, drives the outputs
    entry_t     k_q;   // skid entry, filled only while the consumer stalls
    entry_t     d_in;

    logic in_fire;
    logic out_fire;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr(instr),
        .src  (imm_src_t'(immSrc)),
        .imm  (d_in.imm),
        .bad  (d_in.bad)
    );
    assign d_in.tag = in_tag;

    assign in_ready  = (state != BUF_TWO);
    assign out_valid = (state != BUF_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign immOp   = m_q.imm;
    assign out_tag = m_q.tag;
    assign bad_src = m_q.bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
            m_q   <= '0;
            k_q   <= '0;
        end else if (flush) begin
            // Entries are dropped by state alone; stale data stays hidden
            // behind out_valid=0.
            state <= BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (in_fire) begin
                        m_q   <= d_in;
                        state <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_fire && out_fire) begin
                        m_q <= d_in;
                    end else if (in_fire) begin
                        k_q   <= d_in;
                        state <= BUF_TWO;
                    end else if (out_fire) begin
                        state <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (out_fire) begin
                        m_q   <= k_q;
                        state <= BUF_ONE;
                    end
                end
                default: state <= BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: one 32-bit and one 64-bit instance share all
// inputs; a queue-based reference model predicts both.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, bad32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic        in_ready64, out_valid64, bad64;
    logic [63:0] imm64;
    logic [4:0]  tag64;

    // {bad, tag[4:0], imm[63:0]}
    logic [69:0] exp_q[$];
    logic        zero_data;
    int          n_vec;
    int          n_err;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .ILW(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .immSrc(imm_src), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .immOp(imm32), .out_tag(tag32), .bad_src(bad32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .ILW(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immSrc(imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .immOp(imm64), .out_tag(tag64), .bad_src(bad64)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference immediate from the format rules, using integer arithmetic.
    function automatic logic [69:0] make_entry(input logic [31:0] ins, input logic [2:0] s,
                                               input logic [4:0] t);
        longint      v;
        logic        b;
        logic [63:0] u;
        b = 1'b0;
        v = 0;
        case (s)
            3'd0: v = longint'(ins[31:20]);
            3'd1: begin
                v = longint'(ins[31:20]);
                if (v >= 2048) v = v - 4096;
            end
            3'd2: begin
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (v >= 2048) v = v - 4096;
            end
            3'd3: begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (v >= 4096) v = v - 8192;
            end
            3'd4: begin
                v = longint'(ins[31:12]) * 4096;
                if (ins[31]) v = v - 64'sh1_0000_0000;
            end
            3'd5: begin
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (v >= 1048576) v = v - 2097152;
            end
            3'd6: v = longint'(ins[19:15]);
            default: begin
                v = 0;
                b = 1'b1;
            end
        endcase
        u = v;
        return {b, t, u};
    endfunction

    task automatic check_outputs();
        logic [69:0] e;
        logic [31:0] e32;
        check("in_ready32", in_ready32, exp_q.size() < 2);
        check("in_ready64", in_ready64, exp_q.size() < 2);
        check("out_valid32", out_valid32, exp_q.size() > 0);
        check("out_valid64", out_valid64, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            e   = exp_q[0];
            e32 = e[31:0];
            check("imm32", imm32, e32);
            check("imm64", imm64, e[63:0]);
            check("tag32", tag32, e[68:64]);
            check("tag64", tag64, e[68:64]);
            check("bad32", bad32, e[69]);
            check("bad64", bad64, e[69]);
        end else if (zero_data) begin
            check("rst_imm64", imm64, 64'd0);
            check("rst_tag32", tag32, 5'd0);
            check("rst_bad32", bad32, 1'b0);
        end
    endtask

    task automatic update_model();
        logic ofire, ifire;
        if (!rst_n) begin
            exp_q.delete();
            zero_data = 1'b1;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            ofire = (exp_q.size() > 0) && out_ready;
            ifire = in_valid && (exp_q.size() < 2);
            if (ofire) void'(exp_q.pop_front());
            if (ifire) begin
                exp_q.push_back(make_entry(instr, imm_src, in_tag));
                zero_data = 1'b0;
            end
        end
    endtask

    // Called at a negedge: check, advance one clock, return at next negedge.
    task automatic cycle();
        check_outputs();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] s,
                         input logic [4:0] t, input logic ordy);
        in_valid  = v;
        instr     = ins;
        imm_src   = s;
        in_tag    = t;
        out_ready = ordy;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec     = 0;
        n_err     = 0;
        zero_data = 1'b1;
        rst_n     = 1'b0;
        flush     = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            update_model();
            @(negedge clk);
        end
        rst_n = 1'b1;
        check("reset_in_ready", in_ready32, 1'b1);
        check("reset_out_valid", out_valid32, 1'b0);
        check("reset_imm", imm32, 32'd0);

        // Format examples.
        drive(1'b1, 32'hFFF00093, 3'd1, 5'd3, 1'b1);
        cycle();
        check("t1_i", imm32, 32'hFFFFFFFF);
        drive(1'b1, 32'hFFF00093, 3'd0, 5'd4, 1'b1);
        cycle();
        check("t1_iz", imm32, 32'h00000FFF);
        drive(1'b1, 32'hFE000EE3, 3'd3, 5'd5, 1'b1);
        cycle();
        check("t2_b", imm32, 32'hFFFFFFFC);
        check("t2_b_bit0", imm32[0], 1'b0);
        drive(1'b1, 32'h800000EF, 3'd5, 5'd6, 1'b1);
        cycle();
        check("t2_j", imm32, 32'hFFF00000);
        drive(1'b1, 32'h800002B7, 3'd4, 5'd7, 1'b1);
        cycle();
        check("t2_u64", imm64, 64'hFFFFFFFF80000000);
        drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b1);
        cycle();

        // Back-pressure.
        drive(1'b1, $urandom, 3'd2, 5'd1, 1'b0);
        cycle();
        drive(1'b1, $urandom, 3'd6, 5'd2, 1'b0);
        cycle();
        check("t3_full", in_ready32, 1'b0);
        check("t3_head", tag32, 5'd1);
        drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b0);
        cycle();
        check("t3_hold", tag32, 5'd1);
        out_ready = 1'b1;
        cycle();
        check("t3_second", tag32, 5'd2);
        check("t3_ready", in_ready32, 1'b1);
        cycle();
        check("t3_drained", out_valid32, 1'b0);

        // Streaming with 1-cycle latency.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom, 3'($urandom_range(0, 6)), 5'(i), 1'b1);
            cycle();
            check("t4_tag", tag32, 5'(i));
            check("t4_ready", in_ready32, 1'b1);
        end
        drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b1);
        cycle();

        // Flush while full, with a simultaneous input.
        drive(1'b1, $urandom, 3'd1, 5'd10, 1'b0);
        cycle();
        drive(1'b1, $urandom, 3'd1, 5'd11, 1'b0);
        cycle();
        drive(1'b1, $urandom, 3'd1, 5'd9, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t5_valid", out_valid32, 1'b0);
        check("t5_ready", in_ready32, 1'b1);
        cycle();
        check("t5_dropped", out_valid64, 1'b0);

        // Reset while full, then the reserved format.
        drive(1'b1, $urandom, 3'd4, 5'd12, 1'b0);
        cycle();
        drive(1'b1, $urandom, 3'd4, 5'd13, 1'b0);
        cycle();
        rst_n = 1'b0;
        flush = 1'b1;
        cycle();
        rst_n = 1'b0;
        flush = 1'b0;
        check("t6_imm", imm64, 64'd0);
        check("t6_tag", tag64, 5'd0);
        check("t6_valid", out_valid64, 1'b0);
        check("t6_ready", in_ready64, 1'b1);
        rst_n = 1'b1;
        drive(1'b1, 32'hFFFFFFFF, 3'd7, 5'd14, 1'b1);
        cycle();
        check("t6_rsv_imm", imm32, 32'd0);
        check("t6_rsv_bad", bad32, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                  5'($urandom), $urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b1);
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
